// File: rtl/ingress_classifier.sv
// Per-port ingress stage: buffers each frame, resolves its egress port through the
// shared MAC table, then replays the frame contiguously to the crossbar.
module ingress_classifier #(
   parameter int unsigned P_PORT_ID         = 0,
   parameter int unsigned P_FIFO_ADDR_WIDTH = 6,
   parameter int unsigned P_LKP_TIMEOUT     = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   input  logic        in_last_i,
   output logic        lkp_req_o,
   output logic [47:0] lkp_da_o,
   output logic [47:0] lkp_sa_o,
   input  logic        lkp_ack_i,
   input  logic [2:0]  lkp_dest_i,
   output logic [7:0]  rx_data_o,
   output logic        rx_done_o,
   output logic [2:0]  rx_dest_o,
   output logic        stat_drop_o,
   output logic        stat_flood_o
);
   localparam int unsigned AW         = P_FIFO_ADDR_WIDTH;
   localparam int unsigned DEPTH      = 1 << AW;
   localparam int unsigned TMR_W      = $clog2(P_LKP_TIMEOUT + 1);
   localparam logic [2:0]  IDLE_DEST  = 3'(P_PORT_ID);
   localparam logic [2:0]  FLOOD_DEST = 3'd4;

   typedef struct packed {
      logic [2:0] dest;
      logic       drop;
   } desc_t;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DISCARD, S_GAP} state_t;

   // write side: arm after an idle cycle, count bytes, capture DA/SA
   logic        armed, accept, new_full, new_runt;
   logic [3:0]  cnt;
   logic [87:0] cap;

   assign accept   = in_valid_i && armed;
   assign new_full = accept && (cnt == 4'd11);
   assign new_runt = accept && in_last_i && (cnt < 4'd11);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         armed <= 1'b0;
         cnt   <= '0;
         cap   <= '0;
      end else begin
         armed <= armed | ~in_valid_i;
         if (accept) begin
            if (in_last_i)          cnt <= '0;
            else if (cnt != 4'd12)  cnt <= cnt + 4'd1;
            if (cnt < 4'd11)        cap <= {cap[79:0], in_data_i};
         end
      end
   end

   // byte FIFO of {last, data}
   logic [8:0]  b_mem [DEPTH];
   logic [AW:0] b_wr, b_rd;
   logic        b_full, b_empty, b_push, b_pop;
   logic [8:0]  b_head;

   assign b_full  = (b_wr[AW] != b_rd[AW]) && (b_wr[AW-1:0] == b_rd[AW-1:0]);
   assign b_empty = (b_wr == b_rd);
   assign b_push  = accept && !b_full;
   assign b_head  = b_mem[b_rd[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (b_push) b_mem[b_wr[AW-1:0]] <= {in_last_i, in_data_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         b_wr <= '0;
         b_rd <= '0;
      end else begin
         if (b_push) b_wr <= b_wr + (AW+1)'(1);
         if (b_pop)  b_rd <= b_rd + (AW+1)'(1);
      end
   end

   // lookup control: one request in flight, one job may wait behind it
   logic             pend_valid, pend_runt;
   logic [95:0]      pend_addr, issue_addr;
   logic             issue_pend, issue_new, hold_new, issue_full, issue_runt;
   logic             ack_hit, tmo_hit, d_push;
   logic [TMR_W-1:0] tmr;
   desc_t            d_in;

   always_comb begin
      issue_pend = 1'b0;
      issue_new  = 1'b0;
      hold_new   = 1'b0;
      if (!lkp_req_o) begin
         if (pend_valid) begin
            issue_pend = 1'b1;
            hold_new   = new_full || new_runt;
         end else begin
            issue_new  = new_full || new_runt;
         end
      end else begin
         hold_new = new_full || new_runt;
      end
      issue_runt = issue_pend ? pend_runt : (issue_new && new_runt);
      issue_full = issue_pend ? !pend_runt : (issue_new && new_full);
      issue_addr = issue_pend ? pend_addr : {cap, in_data_i};
      ack_hit    = lkp_req_o && lkp_ack_i;
      tmo_hit    = lkp_req_o && !lkp_ack_i && (tmr == TMR_W'(P_LKP_TIMEOUT - 1));
      d_push     = ack_hit || tmo_hit || issue_runt;
      d_in       = '{dest: IDLE_DEST, drop: 1'b1};
      if (ack_hit) begin
         d_in.dest = (lkp_dest_i > FLOOD_DEST) ? FLOOD_DEST : lkp_dest_i;
         d_in.drop = (lkp_dest_i == IDLE_DEST);
      end else if (tmo_hit) begin
         d_in = '{dest: FLOOD_DEST, drop: 1'b0};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lkp_req_o    <= 1'b0;
         lkp_da_o     <= '0;
         lkp_sa_o     <= '0;
         tmr          <= '0;
         pend_valid   <= 1'b0;
         pend_runt    <= 1'b0;
         pend_addr    <= '0;
         stat_flood_o <= 1'b0;
      end else begin
         stat_flood_o <= tmo_hit;
         if (issue_full) begin
            lkp_req_o            <= 1'b1;
            {lkp_da_o, lkp_sa_o} <= issue_addr;
            tmr                  <= '0;
         end else if (ack_hit || tmo_hit) begin
            lkp_req_o <= 1'b0;
         end else if (lkp_req_o) begin
            tmr <= tmr + TMR_W'(1);
         end
         if (hold_new) begin
            pend_valid <= 1'b1;
            pend_runt  <= new_runt;
            pend_addr  <= {cap, in_data_i};
         end else if (issue_pend) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // two-entry descriptor FIFO
   desc_t      d_mem [2];
   logic       d_wr, d_rd, d_pop, d_full;
   logic [1:0] d_cnt;
   desc_t      d_head;

   assign d_full = (d_cnt == 2'd2);
   assign d_head = d_mem[d_rd];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         d_mem[0] <= '0;
         d_mem[1] <= '0;
         d_wr     <= 1'b0;
         d_rd     <= 1'b0;
         d_cnt    <= '0;
      end else begin
         if (d_push && !d_full) begin
            d_mem[d_wr] <= d_in;
            d_wr        <= ~d_wr;
         end
         if (d_pop) d_rd <= ~d_rd;
         case ({d_push && !d_full, d_pop})
            2'b10:   d_cnt <= d_cnt + 2'd1;
            2'b01:   d_cnt <= d_cnt - 2'd1;
            default: d_cnt <= d_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(accept && b_full)) else $error("ingress_classifier: byte FIFO overflow");
         assert (!(d_push && d_full)) else $error("ingress_classifier: descriptor FIFO overflow");
      end
   end

   // read FSM: replay or discard one frame per descriptor
   state_t     state, state_nxt;
   logic [2:0] cur_dest, cur_dest_nxt, dest_nxt;
   logic [7:0] data_nxt;
   logic       done_nxt, drop_nxt;

   always_comb begin
      state_nxt    = state;
      b_pop        = 1'b0;
      d_pop        = 1'b0;
      data_nxt     = '0;
      done_nxt     = 1'b0;
      dest_nxt     = IDLE_DEST;
      drop_nxt     = 1'b0;
      cur_dest_nxt = cur_dest;
      case (state)
         S_IDLE: begin
            if (d_cnt != 2'd0 && !b_empty) begin
               d_pop = 1'b1;
               b_pop = 1'b1;
               if (d_head.drop) begin
                  drop_nxt  = b_head[8];
                  state_nxt = b_head[8] ? S_GAP : S_DISCARD;
               end else begin
                  data_nxt     = b_head[7:0];
                  done_nxt     = b_head[8];
                  dest_nxt     = d_head.dest;
                  cur_dest_nxt = d_head.dest;
                  state_nxt    = b_head[8] ? S_GAP : S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (!b_empty) begin
               b_pop    = 1'b1;
               data_nxt = b_head[7:0];
               done_nxt = b_head[8];
               dest_nxt = cur_dest;
               if (b_head[8]) state_nxt = S_GAP;
            end
         end
         S_DISCARD: begin
            if (!b_empty) begin
               b_pop = 1'b1;
               if (b_head[8]) begin
                  drop_nxt  = 1'b1;
                  state_nxt = S_GAP;
               end
            end
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         cur_dest    <= IDLE_DEST;
         rx_data_o   <= '0;
         rx_done_o   <= 1'b0;
         rx_dest_o   <= IDLE_DEST;
         stat_drop_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         cur_dest    <= cur_dest_nxt;
         rx_data_o   <= data_nxt;
         rx_done_o   <= done_nxt;
         rx_dest_o   <= dest_nxt;
         stat_drop_o <= drop_nxt;
      end
   end
endmodule

// File: tb/tb_ingress_classifier.sv
// Directed bench for ingress_classifier: frames are driven in a linear sequence, a
// background responder answers lookups, and a monitor logs every non-idle output cycle.
module tb_ingress_classifier;
   localparam int unsigned PORT = 1;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_last_i = 1'b0;
   logic        lkp_req_o;
   logic [47:0] lkp_da_o, lkp_sa_o;
   logic        lkp_ack_i = 1'b0;
   logic [2:0]  lkp_dest_i = '0;
   logic [7:0]  rx_data_o;
   logic        rx_done_o;
   logic [2:0]  rx_dest_o;
   logic        stat_drop_o, stat_flood_o;

   always #5 clk = ~clk;

   ingress_classifier #(.P_PORT_ID(PORT), .P_FIFO_ADDR_WIDTH(6), .P_LKP_TIMEOUT(8)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_last_i(in_last_i),
      .lkp_req_o(lkp_req_o), .lkp_da_o(lkp_da_o), .lkp_sa_o(lkp_sa_o),
      .lkp_ack_i(lkp_ack_i), .lkp_dest_i(lkp_dest_i),
      .rx_data_o(rx_data_o), .rx_done_o(rx_done_o), .rx_dest_o(rx_dest_o),
      .stat_drop_o(stat_drop_o), .stat_flood_o(stat_flood_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [7:0] data;
      logic       done;
      logic [2:0] dest;
   } rec_t;
   rec_t out_q[$];

   int         ack_delay [16];
   logic [2:0] ack_dest [16];
   int ack_idx = 0, ack_wait = 0, drop_cnt = 0, flood_cnt = 0, req_cyc = 0, req_rise = 0;
   bit acked = 0, prev_req = 0;

   // output logger plus lookup responder (ack after ack_delay cycles of req)
   always @(negedge clk) begin
      if (rx_dest_o != 3'(PORT) || rx_done_o || rx_data_o != 8'd0)
         out_q.push_back('{cyc, rx_data_o, rx_done_o, rx_dest_o});
      if (stat_drop_o)  drop_cnt++;
      if (stat_flood_o) flood_cnt++;
      lkp_ack_i  = 1'b0;
      lkp_dest_i = '0;
      if (rst_i) begin
         ack_wait = 0;
         acked    = 0;
      end else if (lkp_req_o) begin
         if (!prev_req) req_rise++;
         req_cyc++;
         if (!acked && ack_wait == ack_delay[ack_idx]) begin
            lkp_ack_i  = 1'b1;
            lkp_dest_i = ack_dest[ack_idx];
            ack_idx++;
            acked = 1;
         end
         ack_wait++;
      end else begin
         if (prev_req && !acked) ack_idx++;
         ack_wait = 0;
         acked    = 0;
      end
      prev_req = lkp_req_o;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input int len, input int base, output int b0);
      b0 = cyc;
      for (int i = 0; i < len; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'(base + i);
         in_last_i  = (i == len - 1);
         tick();
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      in_data_i  = '0;
   endtask

   // compares logged bytes first..first+n-1 with a frame starting at cycle start
   task automatic check_frame(input string tag, input int first, input int n, input int base,
                              input logic [2:0] dest, input int start, input bit has_done);
      for (int i = 0; i < n; i++) begin
         logic [63:0] obs, exp;
         exp = {20'd0, 32'(start + i), 8'(base + i), has_done && (i == n - 1), dest};
         if (first + i < out_q.size())
            obs = {20'd0, 32'(out_q[first+i].c), out_q[first+i].data, out_q[first+i].done, out_q[first+i].dest};
         else
            obs = '1;
         check($sformatf("%s_byte%0d", tag, i), obs, exp);
      end
   endtask

   initial begin
      int b0, b1, s0, r0, q0, d0, f0;
      int bs[4];
      int st, prev_end;
      int dl[4];
      logic [2:0] ds[4], de[4];

      // reset values during and right after reset
      tick(3);
      check("rst_rx", {rx_data_o, rx_done_o, rx_dest_o}, {8'd0, 1'b0, 3'(PORT)});
      check("rst_lkp", {lkp_req_o, stat_drop_o, stat_flood_o, lkp_da_o}, '0);
      rst_i = 1'b0;
      tick();
      check("post_rst_rx", {rx_data_o, rx_done_o, rx_dest_o}, {8'd0, 1'b0, 3'(PORT)});
      check("post_rst_lkp", {lkp_req_o, lkp_sa_o}, '0);
      tick(3);

      // 16-byte frame, zero-wait ack to port 2
      ack_delay[0] = 0; ack_dest[0] = 3'd2;
      s0 = out_q.size(); r0 = req_rise; q0 = req_cyc;
      send_frame(16, 0, b0);
      tick(30);
      check("t1_da", 64'(lkp_da_o), 64'h0000_0001_0203_0405);
      check("t1_sa", 64'(lkp_sa_o), 64'h0000_0607_0809_0A0B);
      check("t1_req_rise", 64'(req_rise - r0), 64'd1);
      check("t1_req_cyc", 64'(req_cyc - q0), 64'd1);
      check("t1_count", 64'(out_q.size() - s0), 64'd16);
      check_frame("t1", s0, 16, 0, 3'd2, b0 + 14, 1);
      check("t1_idle", {rx_data_o, rx_done_o, rx_dest_o}, {8'd0, 1'b0, 3'(PORT)});

      // lookup never acked: flood after timeout
      ack_delay[1] = 1000; ack_dest[1] = 3'd0;
      s0 = out_q.size(); q0 = req_cyc; f0 = flood_cnt;
      send_frame(16, 8'h40, b0);
      tick(40);
      check("t2_req_cyc", 64'(req_cyc - q0), 64'd8);
      check("t2_flood", 64'(flood_cnt - f0), 64'd1);
      check("t2_count", 64'(out_q.size() - s0), 64'd16);
      check_frame("t2", s0, 16, 8'h40, 3'd4, b0 + 21, 1);

      // frame looked up to own port is dropped; next frame to port 3 streams
      ack_delay[2] = 0; ack_dest[2] = 3'(PORT);
      ack_delay[3] = 2; ack_dest[3] = 3'd3;
      s0 = out_q.size(); d0 = drop_cnt;
      send_frame(16, 8'h60, b0);
      tick();
      send_frame(20, 8'h80, b1);
      tick(45);
      check("t3_drop", 64'(drop_cnt - d0), 64'd1);
      check("t3_da", 64'(lkp_da_o), 64'h0000_8081_8283_8485);
      check("t3_count", 64'(out_q.size() - s0), 64'd20);
      check_frame("t3", s0, 20, 8'h80, 3'd3, b1 + 16, 1);

      // 6-byte runt then 64-byte frame with ack delayed 5
      ack_delay[4] = 5; ack_dest[4] = 3'd0;
      s0 = out_q.size(); d0 = drop_cnt; r0 = req_rise;
      send_frame(6, 8'hA0, b0);
      tick();
      send_frame(64, 0, b1);
      tick(90);
      check("t4_req_rise", 64'(req_rise - r0), 64'd1);
      check("t4_drop", 64'(drop_cnt - d0), 64'd1);
      check("t4_count", 64'(out_q.size() - s0), 64'd64);
      check_frame("t4", s0, 64, 0, 3'd0, b1 + 19, 1);

      // four back-to-back 64-byte frames, acks delayed 0/3/7/2
      dl = '{0, 3, 7, 2};
      ds = '{3'd0, 3'd2, 3'd6, 3'd3};
      de = '{3'd0, 3'd2, 3'd4, 3'd3};
      for (int k = 0; k < 4; k++) begin
         ack_delay[5+k] = dl[k];
         ack_dest[5+k]  = ds[k];
      end
      s0 = out_q.size();
      for (int k = 0; k < 4; k++) begin
         send_frame(64, k * 64, bs[k]);
         tick();
      end
      tick(120);
      check("t5_count", 64'(out_q.size() - s0), 64'd256);
      prev_end = -100;
      for (int k = 0; k < 4; k++) begin
         st = bs[k] + 14 + dl[k];
         if (prev_end + 2 > st) st = prev_end + 2;
         check_frame($sformatf("t5_f%0d", k), s0 + 64 * k, 64, k * 64, de[k], st, 1);
         prev_end = st + 63;
      end

      // reset at byte 20 of a 40-byte frame, released two cycles later
      ack_delay[9] = 0; ack_dest[9] = 3'd2;
      s0 = out_q.size(); r0 = req_rise;
      b0 = cyc;
      for (int i = 0; i < 40; i++) begin
         in_valid_i = 1'b1;
         in_data_i  = 8'(8'hC0 + i);
         in_last_i  = (i == 39);
         if (i == 20) rst_i = 1'b1;
         if (i == 21) check("t6_rst_rx", {rx_data_o, rx_done_o, rx_dest_o}, {8'd0, 1'b0, 3'(PORT)});
         if (i == 22) begin
            check("t6_rst_lkp", {lkp_req_o, lkp_da_o}, '0);
            rst_i = 1'b0;
         end
         tick();
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      in_data_i  = '0;
      tick(5);
      check("t6_trunc_count", 64'(out_q.size() - s0), 64'd7);
      check_frame("t6_trunc", s0, 7, 8'hC0, 3'd2, b0 + 14, 0);
      ack_delay[10] = 1; ack_dest[10] = 3'd3;
      send_frame(16, 8'hE0, b1);
      tick(40);
      check("t6_req_rise", 64'(req_rise - r0), 64'd2);
      check("t6_da", 64'(lkp_da_o), 64'h0000_E0E1_E2E3_E4E5);
      check("t6_count", 64'(out_q.size() - s0), 64'd23);
      check_frame("t6_next", s0 + 7, 16, 8'hE0, 3'd3, b1 + 15, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ingress_classifier.md
Name: ingress_classifier

Overview:
- Per-port ingress stage between a MAC receiver and one crossbar RX port.
- Buffers each incoming frame and extracts the destination MAC (DA, bytes 0-5) and source MAC (SA, bytes 6-11).
- Resolves the egress port through a request/acknowledge handshake with the shared MAC table.
- Replays the frame contiguously to the crossbar with rx_dest held constant for the whole frame and rx_done on the last byte.

Parameters:
- P_PORT_ID, 0, index of this ingress port (0-3); also the idle/invalid value driven on rx_dest_o.
- P_FIFO_ADDR_WIDTH, 6, byte FIFO depth = 2**P_FIFO_ADDR_WIDTH entries of 9 bits ({last, data}).
- P_LKP_TIMEOUT, 8, cycles lkp_req_o may stay high without lkp_ack_i before the frame is flooded.

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- in_data_i  in  8  frame byte from MAC RX
- in_valid_i  in  1  byte valid; contiguous within a frame; at least 1 idle cycle between frames
- in_last_i  in  1  last byte of frame; qualified by in_valid_i
- lkp_req_o  out  1  lookup request; held until ack or timeout
- lkp_da_o  out  48  captured DA, byte 0 in bits [47:40]; stable while lkp_req_o is high
- lkp_sa_o  out  48  captured SA, same byte order
- lkp_ack_i  in  1  lookup done; sampled only while lkp_req_o is high
- lkp_dest_i  in  3  egress port 0-3, or 4 = broadcast; valid with lkp_ack_i
- rx_data_o  out  8  byte to crossbar
- rx_done_o  out  1  high on the last byte of a frame
- rx_dest_o  out  3  egress for the current frame; P_PORT_ID when idle
- stat_drop_o  out  1  one-cycle pulse per dropped frame
- stat_flood_o  out  1  one-cycle pulse per frame flooded on timeout

Behaviour:
Reset:
- All outputs registered.
- During reset and in the cycle after: rx_data_o=0, rx_done_o=0, rx_dest_o=P_PORT_ID, lkp_req_o=0, lkp_da_o=0, lkp_sa_o=0, stat pulses 0.
- Byte FIFO and descriptor FIFO emptied; lookup pending and byte counters cleared.
- After reset, input is ignored until a cycle with in_valid_i=0 is seen, so a partial frame is never written.

Write side:
- Every accepted byte is pushed into the FIFO with its in_last_i flag.
- A byte counter (saturating at 12) steers bytes 0-5 into DA and bytes 6-11 into SA.

Lookup:
- The cycle after byte 11 is accepted, lkp_req_o rises.
- If the previous lookup is still pending, the request is deferred until that lookup completes.
- Ack in the same cycle as req rise is legal.
- Ack cycle A: lkp_req_o falls in A+1 and a descriptor {dest, drop} is pushed in A+1.
  - lkp_dest_i==P_PORT_ID: drop=1.
  - lkp_dest_i>4: dest=4.
- Timeout: P_LKP_TIMEOUT cycles with no ack → req falls, descriptor dest=4, one-cycle stat_flood_o pulse.
- Runt (in_last_i before byte 11): no lookup; a drop=1 descriptor is pushed the cycle after the last byte.

Descriptor FIFO and overflow:
- Descriptor FIFO depth is 2.
- Byte FIFO overflow and descriptor overflow are illegal under the interface rules, provided the FIFO depth is at least P_LKP_TIMEOUT+16.
- A push while full discards the byte and is flagged by a simulation assertion.

Read FSM:
- IDLE:
  - descriptor present and drop=0 → STREAM.
  - descriptor present and drop=1 → DISCARD.
  - The descriptor is popped on entry.
- STREAM:
  - Pop one byte per cycle. Next cycle: rx_data_o=byte, rx_done_o=last flag, rx_dest_o=dest.
  - The popped last flag → GAP.
  - The FIFO can never go empty mid-frame, because a descriptor exists only after 12 bytes are stored and input is 1 byte/cycle.
- DISCARD:
  - Pop one byte per cycle; outputs stay idle.
  - On the popped last flag: one-cycle stat_drop_o pulse → GAP.
- GAP:
  - One cycle with outputs idle (data 0, done 0, dest P_PORT_ID) → IDLE.

Latency:
- Byte 11 accepted in cycle C, ack in C+1 → first output byte in C+3.
- Input byte 0 to output byte 0 is 14 cycles with zero-wait lookup.
- Each extra ack wait cycle adds 1.

Simultaneous events:
- Write and read in the same cycle are both performed.
- Descriptor push and pop in the same cycle are both performed.

Reset mid-frame:
- Output goes idle next cycle with no rx_done_o.
- The upstream crossbar must treat that frame as truncated.

Test Plan:
- Reset, then a 16-byte frame 0x00..0x0F, ack at req+0 with dest=2 → lkp_da_o=0x000102030405, lkp_sa_o=0x060708090A0B; rx_data_o 0x00..0x0F on 16 consecutive cycles starting 14 cycles after byte 0; rx_dest_o=2 throughout; rx_done_o only on 0x0F; then idle with rx_dest_o=P_PORT_ID.
- Lookup never acked, P_LKP_TIMEOUT=8 → lkp_req_o high exactly 8 cycles; one stat_flood_o pulse; frame output with rx_dest_o=4.
- P_PORT_ID=1, ack with dest=1 → no output change on rx_*; one stat_drop_o pulse; a following frame to dest 3 is streamed intact.
- 6-byte runt → no lkp_req_o, one stat_drop_o pulse, rx_* stays idle; a back-to-back 64-byte frame after a 1-cycle gap with ack delayed 5 cycles → streamed contiguously, with exactly one idle GAP cycle after the preceding frame.
- Four back-to-back 64-byte frames with acks delayed 0/3/7/2 cycles → all 256 bytes match in order, and rx_dest_o changes only in GAP cycles.
- rst_i asserted at byte 20 of a 40-byte frame, released 2 cycles later mid-frame → rx_* idle from the cycle after assertion; the remaining input bytes are ignored; the next full frame is classified and streamed correctly.
